// File: rtl/spi_pkg.sv
// Shared types and helpers for the full-duplex SPI master.
// State encoding, {cpol,cpha} mode constants and select-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int spi_csw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK timebase: divider counter, half-period tick and edge classification.
// hp_q counts half-periods since LEAD entry; edge n = hp_q+1.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int DIV   = 25,
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o,
  output logic lead_o,
  output logic final_o,
  output logic done_o
);

  localparam int CW = spi_csw(DIV);
  localparam int HW = spi_csw(2 * WIDTH + 2);

  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hp_q;

  assign tick_o  = (cnt_q == CW'(DIV - 1));
  assign lead_o  = ~hp_q[0];
  assign final_o = (hp_q == HW'(2 * WIDTH - 1));
  assign done_o  = (hp_q == HW'(2 * WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hp_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      hp_q  <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
      hp_q  <= hp_q + HW'(1);
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_duplex.sv
// Full-duplex SPI master, all four CPOL/CPHA modes, registered SCK.
// Optional LSB-first bit order enabled by defining SPI_LSB_FIRST_EN.
module spi_master_duplex
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 25,
  parameter int NCS   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [WIDTH-1:0]        tx_data,
  input  logic [spi_csw(NCS)-1:0] cs_sel,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  output logic                    rx_valid,
  output logic [WIDTH-1:0]        rx_data,
  output logic                    busy,
  output logic                    sck,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NCS-1:0]          cs_n
);

  localparam int CSW = spi_csw(NCS);

  spi_state_e       st_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [WIDTH-1:0] tx_sr_q;
  logic [WIDTH-1:0] rx_sr_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic             sck_q;
  logic             mosi_q;
  logic [NCS-1:0]   cs_n_q;

  logic [WIDTH-1:0] tx_nx_d;
  logic [WIDTH-1:0] rx_nx_d;
  logic             mosi_nx_d;
  logic             first_d;
  logic [NCS-1:0]   cs_on;
  logic             lsb_q;
  logic             lsb_now;

  logic tick;
  logic lead;
  logic final_e;
  logic done;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_now = lsb_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_q <= 1'b0;
    end else if (st_q == ST_IDLE && tx_valid) begin
      lsb_q <= lsb_first;
    end
  end
`else
  logic unused_lsb;
  assign unused_lsb = lsb_first;
  assign lsb_now    = 1'b0;
  assign lsb_q      = 1'b0;
`endif

  spi_sck_gen #(
    .DIV  (DIV),
    .WIDTH(WIDTH)
  ) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (st_q == ST_IDLE),
    .tick_o (tick),
    .lead_o (lead),
    .final_o(final_e),
    .done_o (done)
  );

  always_comb begin
    cs_on = '0;
    for (int i = 0; i < NCS; i++) begin
      cs_on[i] = (cs_sel == CSW'(i));
    end
  end

  always_comb begin
    first_d = lsb_now ? tx_data[0] : tx_data[WIDTH-1];
    if (lsb_q) begin
      tx_nx_d   = tx_sr_q >> 1;
      mosi_nx_d = tx_sr_q[1];
      rx_nx_d   = {miso, rx_sr_q[WIDTH-1:1]};
    end else begin
      tx_nx_d   = tx_sr_q << 1;
      mosi_nx_d = tx_sr_q[WIDTH-2];
      rx_nx_d   = {rx_sr_q[WIDTH-2:0], miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          sck_q  <= cpol;
          mosi_q <= 1'b0;
          if (tx_valid) begin
            st_q    <= ST_LEAD;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            tx_sr_q <= tx_data;
            rx_sr_q <= '0;
            mosi_q  <= first_d;
            cs_n_q  <= ~cs_on;
          end
        end
        ST_LEAD: begin
          if (tick) begin
            st_q  <= ST_SHIFT;
            sck_q <= ~sck_q;
            if (!cpha_q) rx_sr_q <= rx_nx_d;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (done) begin
              st_q <= ST_TRAIL;
            end else begin
              sck_q <= ~sck_q;
              // sample on the edge matching cpha, shift on the other
              if (lead ^ cpha_q) begin
                rx_sr_q <= rx_nx_d;
              end else if (cpha_q || !final_e) begin
                tx_sr_q <= tx_nx_d;
                mosi_q  <= mosi_nx_d;
              end
            end
          end
        end
        ST_TRAIL: begin
          if (tick) begin
            st_q       <= ST_IDLE;
            cs_n_q     <= '1;
            rx_data_q  <= rx_sr_q;
            rx_valid_q <= 1'b1;
            mosi_q     <= 1'b0;
            sck_q      <= cpol_q;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready = (st_q == ST_IDLE);
  assign busy     = ~tx_ready;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule
